// File: rtl/rom_stats_scanner.sv
`default_nettype none
// ============================================================================
// Module   : rom_stats_scanner
// Function : Scans a registered-read ROM and reports the sum, max, min,
//            average and remainder of its entries. The optional pass counter
//            is enabled with `define STATS_THRESH_EN.
// Revision : 1.0
// ============================================================================
module rom_stats_scanner #(
   parameter int N_ENTRIES = 11,
   parameter int DW        = 8,
   parameter int AW        = 8,
   parameter int SUM_W     = 12,
   parameter int THRESH    = 70
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   output logic [AW-1:0]    rom_addr_o,
   input  logic [DW-1:0]    rom_data_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [SUM_W-1:0] sum_o,
   output logic [DW-1:0]    max_val_o,
   output logic [DW-1:0]    min_val_o,
   output logic [DW-1:0]    avg_o,
   output logic [DW-1:0]    rem_o,
   output logic [AW:0]      pass_count_o
);

   localparam int CW  = AW + 1;
   localparam int RW  = AW + 2;
   localparam int DCW = $clog2(SUM_W + 1);

   localparam logic [AW-1:0]  C_LAST_ADDR = AW'(N_ENTRIES - 1);
   localparam logic [CW-1:0]  C_N_CNT     = CW'(N_ENTRIES);
   localparam logic [CW-1:0]  C_LAST_CAP  = CW'(N_ENTRIES - 1);
   localparam logic [RW-1:0]  C_DIVISOR   = RW'(N_ENTRIES);
   localparam logic [DCW-1:0] C_LAST_STEP = DCW'(SUM_W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    iss_q;
   logic [CW-1:0]    cap_q;
   logic             vld_q;
   logic [SUM_W-1:0] sum_q;
   logic [DW-1:0]    max_q;
   logic [DW-1:0]    min_q;
   logic [SUM_W-1:0] sq_q;
   logic [AW:0]      rem_q;
   logic [DCW-1:0]   dcnt_q;

   logic [SUM_W-1:0] sum_d;
   logic [RW-1:0]    trial_d;
   logic             qbit_d;
   logic [AW:0]      rem_d;
   logic [SUM_W-1:0] quot_d;

   // sq_q starts as the dividend and fills with quotient bits from the LSB.
   assign sum_d   = sum_q + SUM_W'(rom_data_i);
   assign trial_d = {rem_q, sq_q[SUM_W-1]};
   assign qbit_d  = (trial_d >= C_DIVISOR);
   assign rem_d   = qbit_d ? (AW+1)'(trial_d - C_DIVISOR) : trial_d[AW:0];
   assign quot_d  = {sq_q[SUM_W-2:0], qbit_d};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         iss_q      <= '0;
         cap_q      <= '0;
         vld_q      <= 1'b0;
         sum_q      <= '0;
         max_q      <= '0;
         min_q      <= '1;
         sq_q       <= '0;
         rem_q      <= '0;
         dcnt_q     <= '0;
         rom_addr_o <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         sum_o      <= '0;
         max_val_o  <= '0;
         min_val_o  <= '1;
         avg_o      <= '0;
         rem_o      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q    <= S_SCAN;
                  busy_o     <= 1'b1;
                  rom_addr_o <= '0;
                  iss_q      <= '0;
                  cap_q      <= '0;
                  vld_q      <= 1'b0;
                  sum_q      <= '0;
                  max_q      <= '0;
                  min_q      <= '1;
               end
            end
            S_SCAN: begin
               if (rom_addr_o != C_LAST_ADDR) begin
                  rom_addr_o <= rom_addr_o + 1'b1;
               end
               // vld_q marks the cycle in which the ROM presents a requested word.
               if (iss_q != C_N_CNT) begin
                  iss_q <= iss_q + 1'b1;
                  vld_q <= 1'b1;
               end else begin
                  vld_q <= 1'b0;
               end
               if (vld_q) begin
                  sum_q <= sum_d;
                  max_q <= (rom_data_i > max_q) ? rom_data_i : max_q;
                  min_q <= (rom_data_i < min_q) ? rom_data_i : min_q;
                  cap_q <= cap_q + 1'b1;
                  if (cap_q == C_LAST_CAP) begin
                     state_q <= S_DIV;
                     sq_q    <= sum_d;
                     rem_q   <= '0;
                     dcnt_q  <= '0;
                  end
               end
            end
            S_DIV: begin
               sq_q   <= quot_d;
               rem_q  <= rem_d;
               dcnt_q <= dcnt_q + 1'b1;
               if (dcnt_q == C_LAST_STEP) begin
                  state_q   <= S_DONE;
                  busy_o    <= 1'b0;
                  done_o    <= 1'b1;
                  sum_o     <= sum_q;
                  max_val_o <= max_q;
                  min_val_o <= min_q;
                  avg_o     <= quot_d[DW-1:0];
                  rem_o     <= rem_d[DW-1:0];
               end
            end
            S_DONE: begin
               done_o  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef STATS_THRESH_EN
   logic [AW:0] pass_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_q       <= '0;
         pass_count_o <= '0;
      end else begin
         if (state_q == S_IDLE && start_i) begin
            pass_q <= '0;
         end else if (state_q == S_SCAN && vld_q && rom_data_i >= DW'(THRESH)) begin
            pass_q <= pass_q + 1'b1;
         end
         if (state_q == S_DIV && dcnt_q == C_LAST_STEP) begin
            pass_count_o <= pass_q;
         end
      end
   end
`else
   assign pass_count_o = '0;
`endif

endmodule
`default_nettype wire
